circ_wr_arbiter: RTL and testbench

//  Round-robin write arbiter sharing one circular_buffer write port among N producers.

---
 rtl/circ_wr_arbiter.sv | 98 +++++++++
 tb/tb_circ_wr_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/circ_wr_arbiter.sv
// Round-robin write arbiter: N producers share one circular_buffer write port.
// One owner is granted per burst of up to BURST_LEN writes. No write is issued while the buffer is full.
module circ_wr_arbiter #(
  parameter int unsigned N         = 4,
  parameter int unsigned W         = 3,
  parameter int unsigned BURST_LEN = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  input  logic [N*W-1:0]       din,
  output logic [N-1:0]         ack,
  input  logic                 buf_full,
  output logic                 buf_wr,
  output logic [W-1:0]         buf_din,
  output logic [$clog2(N)-1:0] owner,
  output logic                 busy
);

  localparam int unsigned OW = $clog2(N);
  localparam int unsigned CW = $clog2(BURST_LEN + 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t        state;
  logic [OW-1:0] rr_ptr;
  logic [CW-1:0] beat_cnt;
  logic [OW-1:0] pick;
  logic [OW-1:0] cand;
  logic          found;
  logic [OW-1:0] next_ptr;
  logic          last_beat;

  // First requester at or after rr_ptr, wrapping modulo N
  always_comb begin
    pick  = rr_ptr;
    found = 1'b0;
    cand  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = OW'((32'(rr_ptr) + k) % N);
      if (!found && req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  assign next_ptr  = (32'(owner) == N - 1) ? '0 : owner + OW'(1);
  assign last_beat = (beat_cnt == CW'(BURST_LEN - 1));

  // Write path is combinational on req/buf_full so a full buffer is never written
  always_comb begin
    buf_wr  = 1'b0;
    ack     = '0;
    buf_din = '0;
    if (state == BURST) begin
      buf_wr     = req[owner] & ~buf_full;
      ack[owner] = buf_wr;
      buf_din    = din[32'(owner)*W +: W];
    end
  end

  assign busy = (state == BURST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      owner    <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            owner    <= pick;
            beat_cnt <= '0;
            state    <= BURST;
          end
        end
        BURST: begin
          // Release wins over a simultaneous full deassert
          if (!req[owner]) begin
            state  <= IDLE;
            rr_ptr <= next_ptr;
          end else if (!buf_full) begin
            beat_cnt <= beat_cnt + CW'(1);
            if (last_beat) begin
              state  <= IDLE;
              rr_ptr <= next_ptr;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_circ_wr_arbiter.sv
// Bench for circ_wr_arbiter: directed scenarios plus randomized producers, checked
// cycle by cycle against a rule-level arbiter model and a queue model of the buffer.
module tb_circ_wr_arbiter;

  localparam int N = 4;
  localparam int W = 3;
  localparam int BL = 4;
  localparam int DEPTH = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic [N-1:0]  req;
  logic [N*W-1:0] din;
  logic [N-1:0]  ack;
  logic          buf_full;
  logic          buf_wr;
  logic [W-1:0]  buf_din;
  logic [1:0]    owner;
  logic          busy;

  logic          rd;
  int            vectors = 0;
  int            miscompares = 0;
  int            obs_acks;
  int            sum_wr;
  int            sum_rd;
  logic [N-1:0]  last_ack;
  logic [2:0]    wr_log[$];
  logic [2:0]    bq[$];

  // arbiter model
  bit m_busy;
  int m_owner;
  int m_beats;
  int m_ptr;

  circ_wr_arbiter #(.N(N), .W(W), .BURST_LEN(BL)) dut (
    .clock(clock), .reset(reset), .req(req), .din(din), .ack(ack),
    .buf_full(buf_full), .buf_wr(buf_wr), .buf_din(buf_din),
    .owner(owner), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_beats = 0; m_ptr = 0;
  endtask

  // One clock: compare outputs before the edge, then advance buffer and model
  task automatic step();
    bit         full;
    bit         ew;
    logic [3:0] ea;
    logic [2:0] ed;
    logic       dw;
    logic [2:0] dd;
    full = (bq.size() >= DEPTH);
    buf_full = full;
    #1;
    ew = m_busy && req[m_owner] && !full;
    ea = ew ? 4'(1 << m_owner) : 4'b0000;
    ed = m_busy ? din[m_owner*W +: W] : 3'b000;
    vectors++;
    if (ack !== ea) begin miscompares++; $display("FAIL ack: got %b exp %b", ack, ea); end
    vectors++;
    if (buf_wr !== ew) begin miscompares++; $display("FAIL buf_wr: got %b exp %b", buf_wr, ew); end
    vectors++;
    if (buf_din !== ed) begin miscompares++; $display("FAIL buf_din: got %0d exp %0d", buf_din, ed); end
    vectors++;
    if (busy !== m_busy) begin miscompares++; $display("FAIL busy: got %b exp %b", busy, m_busy); end
    if (m_busy) begin
      vectors++;
      if (owner !== 2'(m_owner)) begin miscompares++; $display("FAIL owner: got %0d exp %0d", owner, m_owner); end
    end
    if (full && buf_wr === 1'b1) begin
      miscompares++; $display("FAIL wr_while_full: buf_wr=1 with buffer full");
    end
    last_ack = ea;
    dw = buf_wr;
    dd = buf_din;
    if (ack !== 4'b0000) obs_acks++;
    if (dw === 1'b1) begin sum_wr += int'(dd); wr_log.push_back(dd); end
    @(posedge clock);
    if (rd && bq.size() > 0) sum_rd += int'(bq.pop_front());
    if (dw === 1'b1) bq.push_back(dd);
    if (!m_busy) begin
      for (int k = 0; k < N; k++) begin
        if (!m_busy && req[(m_ptr + k) % N]) begin
          m_owner = (m_ptr + k) % N;
          m_busy = 1;
        end
      end
      m_beats = 0;
    end else if (!req[m_owner]) begin
      m_busy = 0; m_ptr = (m_owner + 1) % N;
    end else if (ew) begin
      m_beats++;
      if (m_beats == BL) begin m_busy = 0; m_ptr = (m_owner + 1) % N; end
    end
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    bq = {};
    wr_log = {};
    obs_acks = 0; sum_wr = 0; sum_rd = 0;
  endtask

  task automatic test_reset();
    req = 4'b1111; din = {3'd3, 3'd2, 3'd1, 3'd0}; rd = 0; buf_full = 0;
    reset = 1'b1;
    #1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      vectors++;
      if (ack !== 4'b0 || buf_wr !== 1'b0 || busy !== 1'b0 || buf_din !== 3'b0) begin
        miscompares++;
        $display("FAIL reset_outputs: ack=%b wr=%b busy=%b din=%0d exp all 0", ack, buf_wr, busy, buf_din);
      end
    end
    reset = 1'b0;
    model_reset(); bq = {}; obs_acks = 0;
    step();
    step();
    vectors++;
    if (busy !== 1'b1 || owner !== 2'd0) begin
      miscompares++; $display("FAIL first_grant: busy=%b owner=%0d exp 1/0", busy, owner);
    end
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0100; din = {3'd0, 3'b101, 3'd0, 3'd0};
    for (int c = 0; c < 7; c++) step();
    vectors++;
    if (obs_acks != 5) begin miscompares++; $display("FAIL single_acks: got %0d exp 5", obs_acks); end
    req = 4'b0000;
    step();
  endtask

  task automatic test_round_robin();
    logic [2:0] e;
    do_reset();
    req = 4'b1111; din = {3'd3, 3'd2, 3'd1, 3'd0}; rd = 1;
    for (int c = 0; c < 20; c++) step();
    vectors++;
    if (wr_log.size() != 16) begin
      miscompares++; $display("FAIL rr_count: got %0d writes exp 16", wr_log.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        e = 3'(i / BL);
        vectors++;
        if (wr_log[i] !== e) begin miscompares++; $display("FAIL rr_order[%0d]: got %0d exp %0d", i, wr_log[i], e); end
      end
    end
    req = 4'b0000; rd = 0;
    step(); step();
  endtask

  task automatic test_full_stall();
    do_reset();
    req = 4'b0001; din = {9'd0, 3'($urandom_range(1, 7))}; rd = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (last_ack[0]) din[2:0] = 3'($urandom_range(0, 7));
    end
    vectors++;
    if (obs_acks != 8) begin miscompares++; $display("FAIL full_acks: got %0d exp 8", obs_acks); end
    rd = 1; step(); rd = 0;
    if (last_ack[0]) din[2:0] = 3'($urandom_range(0, 7));
    for (int c = 0; c < 6; c++) begin
      step();
      if (last_ack[0]) din[2:0] = 3'($urandom_range(0, 7));
    end
    vectors++;
    if (obs_acks != 9) begin miscompares++; $display("FAIL full_one_more: got %0d exp 9", obs_acks); end
    req = 4'b0000; rd = 1;
    for (int c = 0; c < 12; c++) step();
    vectors++;
    if (sum_rd != sum_wr || bq.size() != 0) begin
      miscompares++; $display("FAIL full_sum: read %0d exp %0d (left %0d)", sum_rd, sum_wr, bq.size());
    end
    rd = 0;
  endtask

  task automatic test_early_release();
    do_reset();
    req = 4'b0010; din = {3'd7, 3'd0, 3'd5, 3'd0};
    step(); step(); step();
    vectors++;
    if (obs_acks != 2) begin miscompares++; $display("FAIL early_acks: got %0d exp 2", obs_acks); end
    req = 4'b1000;
    step();
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL early_idle: busy=%b exp 0", busy); end
    req = 4'b1010;
    step(); step();
    vectors++;
    if (owner !== 2'd3) begin miscompares++; $display("FAIL early_next_owner: got %0d exp 3", owner); end
    req = 4'b0000;
    step(); step();
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 4'b0010; din = {3'd6, 3'd0, 3'd4, 3'd0};
    step();
    req = 4'b0000;
    step();
    req = 4'b1000;
    step(); step(); step();
    reset = 1'b1;
    #1;
    vectors++;
    if (ack !== 4'b0 || buf_wr !== 1'b0 || busy !== 1'b0 || buf_din !== 3'b0) begin
      miscompares++;
      $display("FAIL mid_reset_outputs: ack=%b wr=%b busy=%b din=%0d exp all 0", ack, buf_wr, busy, buf_din);
    end
    @(posedge clock); @(negedge clock);
    reset = 1'b0;
    model_reset();
    vectors++;
    if (bq.size() != 2) begin miscompares++; $display("FAIL mid_reset_words: got %0d exp 2", bq.size()); end
    req = 4'b1111;
    step(); step();
    vectors++;
    if (owner !== 2'd0) begin miscompares++; $display("FAIL mid_reset_ptr: owner %0d exp 0", owner); end
    req = 4'b0000;
    step(); step();
  endtask

  task automatic test_random();
    do_reset();
    req = 4'b0000;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (req[i] && last_ack[i]) begin
          req[i] = ($urandom_range(0, 3) != 0);
          din[i*W +: W] = 3'($urandom_range(0, 7));
        end else if (req[i]) begin
          if ($urandom_range(0, 15) == 0) req[i] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          req[i] = 1'b1;
          din[i*W +: W] = 3'($urandom_range(0, 7));
        end
      end
      rd = ($urandom_range(0, 2) == 0);
      step();
    end
    req = 4'b0000; rd = 1;
    for (int c = 0; c < 12; c++) step();
    vectors++;
    if (sum_rd != sum_wr) begin miscompares++; $display("FAIL random_sum: read %0d exp %0d", sum_rd, sum_wr); end
    rd = 0;
  endtask

  initial begin
    reset = 1'b1; req = '0; din = '0; rd = 0; buf_full = 0; last_ack = '0;
    obs_acks = 0; sum_wr = 0; sum_rd = 0;
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_full_stall();
    test_early_release();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
